// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  localparam int unsigned DIV_XLEN   = 32;
  localparam int unsigned DIV_ITER   = 32;
  localparam int unsigned DIV_ITER_W = 5;

  localparam logic [31:0] DIV_DBZ_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_QUOT = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

endpackage

// File: rtl/add_subtract.sv
// 32-bit adder/subtractor; cin_i=1 selects subtraction (a + ~b + 1), cin_i=0 plain a + b.
module add_subtract (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] result_o,
  output logic        cout_o
);

  logic [31:0] b_eff;
  logic [32:0] sum;

  // Invert b in subtract mode so the carry-in completes the two's complement.
  always_comb begin
    b_eff = cin_i ? ~b_i : b_i;
    sum   = {1'b0, a_i} + {1'b0, b_eff} + {32'b0, cin_i};
  end

  assign result_o = sum[31:0];
  assign cout_o   = sum[32];

endmodule

// File: rtl/div_seq_unit.sv
// Sequential restoring divider, one quotient bit per cycle.
// Optional signed support (sign fix-up, overflow shortcut) is compiled in with DIV_SIGNED_EN.
module div_seq_unit
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            dbz_o
);

  div_state_e state_q, state_d;

  logic [DIV_ITER_W-1:0] iter_q, iter_d;
  logic [DIV_XLEN-1:0]   dvd_q, dvd_d;
  logic [DIV_XLEN-1:0]   dsr_q, dsr_d;
  logic [DIV_XLEN-1:0]   rem_q, rem_d;
  logic [DIV_XLEN-1:0]   quot_q, quot_d;
  logic [DIV_XLEN-1:0]   remd_q, remd_d;
  logic                  dbz_q, dbz_d;

  // Trial subtraction datapath.
  logic [DIV_XLEN-1:0] shifted;
  logic [DIV_XLEN-1:0] sub_res;
  logic                sub_cout;
  logic                qbit;
  logic [DIV_XLEN-1:0] rem_step;
  logic [DIV_XLEN-1:0] dvd_step;

  assign shifted = {rem_q[DIV_XLEN-2:0], dvd_q[DIV_XLEN-1]};

  add_subtract u_trial_sub (
    .a_i      (shifted),
    .b_i      (dsr_q),
    .cin_i    (1'b1),
    .result_o (sub_res),
    .cout_o   (sub_cout)
  );

  // rem_q[31] set means the true shifted value exceeds 32 bits, so it is surely >= divisor.
  assign qbit     = rem_q[DIV_XLEN-1] | sub_cout;
  assign rem_step = qbit ? sub_res : shifted;
  assign dvd_step = {dvd_q[DIV_XLEN-2:0], qbit};

`ifdef DIV_SIGNED_EN
  logic                neg_q_q, neg_q_d;
  logic                neg_r_q, neg_r_d;
  logic [DIV_XLEN-1:0] nega_b, nega_res;
  logic [DIV_XLEN-1:0] negb_b, negb_res;
  logic                unused_nega_cout, unused_negb_cout;
  logic                ovf;

  // Negators take absolute values on accept and apply the sign fix-up in FIX.
  assign nega_b = (state_q == StFix) ? dvd_q : dividend_i;
  assign negb_b = (state_q == StFix) ? rem_q : divisor_i;

  add_subtract u_neg_quot (
    .a_i      (32'h0),
    .b_i      (nega_b),
    .cin_i    (1'b1),
    .result_o (nega_res),
    .cout_o   (unused_nega_cout)
  );

  add_subtract u_neg_rem (
    .a_i      (32'h0),
    .b_i      (negb_b),
    .cin_i    (1'b1),
    .result_o (negb_res),
    .cout_o   (unused_negb_cout)
  );

  assign ovf = signed_i && (dividend_i == DIV_OVF_QUOT) && (divisor_i == 32'hFFFF_FFFF);

  // Sign flags for the final fix-up.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = signed_i;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            state_d = StDone;
            quot_d  = DIV_DBZ_QUOT;
            remd_d  = dividend_i;
            dbz_d   = 1'b1;
`ifdef DIV_SIGNED_EN
          end else if (ovf) begin
            state_d = StDone;
            quot_d  = DIV_OVF_QUOT;
            remd_d  = '0;
            dbz_d   = 1'b0;
`endif
          end else begin
            state_d = StCalc;
            iter_d  = '0;
            rem_d   = '0;
`ifdef DIV_SIGNED_EN
            dvd_d   = (signed_i && dividend_i[DIV_XLEN-1]) ? nega_res : dividend_i;
            dsr_d   = (signed_i && divisor_i[DIV_XLEN-1]) ? negb_res : divisor_i;
            neg_q_d = signed_i & (dividend_i[DIV_XLEN-1] ^ divisor_i[DIV_XLEN-1]);
            neg_r_d = signed_i & dividend_i[DIV_XLEN-1];
`else
            dvd_d   = dividend_i;
            dsr_d   = divisor_i;
`endif
          end
        end
      end
      StCalc: begin
        rem_d  = rem_step;
        dvd_d  = dvd_step;
        iter_d = iter_q + DIV_ITER_W'(1);
        if (iter_q == DIV_ITER_W'(DIV_ITER - 1)) begin
`ifdef DIV_SIGNED_EN
          state_d = StFix;
`else
          state_d = StDone;
          quot_d  = dvd_step;
          remd_d  = rem_step;
          dbz_d   = 1'b0;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      StFix: begin
        state_d = StDone;
        quot_d  = neg_q_q ? nega_res : dvd_q;
        remd_d  = neg_r_q ? negb_res : rem_q;
        dbz_d   = 1'b0;
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      iter_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready_o     = (state_q == StIdle);
  assign done_o      = (state_q == StDone);
  assign quotient_o  = quot_q;
  assign remainder_o = remd_q;
  assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed self-checking bench for div_seq_unit; expectations follow DIV_SIGNED_EN.
module tb_div_seq_unit;

`ifdef DIV_SIGNED_EN
  localparam int LAT_NORM = 34;
`else
  localparam int LAT_NORM = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        ready_o, done_o, dbz_o;
  logic [31:0] quotient_o, remainder_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  div_seq_unit #(.XLEN(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .signed_i    (sgn),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .dbz_o       (dbz_o)
  );

  // Issue one request from a negedge; returns latency (-1 on timeout) and the results.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q, output logic [31:0] r,
                        output logic dz);
    int w;
    w = 0;
    while (!ready_o && w < 60) begin
      @(negedge clk);
      w++;
    end
    start = 1'b1; sgn = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; sgn = ~s; dividend = 32'hA5A5_5A5A; divisor = 32'h0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done_o) begin
        lat = c;
        break;
      end
    end
    q = quotient_o; r = remainder_o; dz = dbz_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vec_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    vec_cnt++; if (done_o !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b want 0", done_o); end
    vec_cnt++; if (quotient_o !== 32'h0) begin err_cnt++; $display("FAIL rst_quot: got %h want 0", quotient_o); end
    vec_cnt++; if (remainder_o !== 32'h0) begin err_cnt++; $display("FAIL rst_rem: got %h want 0", remainder_o); end
    vec_cnt++; if (dbz_o !== 1'b0) begin err_cnt++; $display("FAIL rst_dbz: got %b want 0", dbz_o); end
  endtask

  task automatic test_unsigned();
    int lat; logic [31:0] q, r; logic dz;
    run_op(1'b0, 32'd100, 32'd7, lat, q, r, dz);
    vec_cnt++; if (q !== 32'd14) begin err_cnt++; $display("FAIL u100_7_q: got %h want %h", q, 32'd14); end
    vec_cnt++; if (r !== 32'd2) begin err_cnt++; $display("FAIL u100_7_r: got %h want %h", r, 32'd2); end
    vec_cnt++; if (dz !== 1'b0) begin err_cnt++; $display("FAIL u100_7_dbz: got %b want 0", dz); end
    vec_cnt++; if (lat !== LAT_NORM) begin err_cnt++; $display("FAIL u100_7_lat: got %0d want %0d", lat, LAT_NORM); end
    @(negedge clk);
    vec_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL u_ready_back: got %b want 1", ready_o); end
    repeat (3) @(negedge clk);
    vec_cnt++; if (quotient_o !== 32'd14) begin err_cnt++; $display("FAIL u_held_q: got %h want %h", quotient_o, 32'd14); end
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, lat, q, r, dz);
    vec_cnt++; if (q !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL umax_1_q: got %h want ffffffff", q); end
    vec_cnt++; if (r !== 32'h0) begin err_cnt++; $display("FAIL umax_1_r: got %h want 0", r); end
    run_op(1'b0, 32'h1234_5678, 32'h1000, lat, q, r, dz);
    vec_cnt++; if (q !== 32'h0001_2345) begin err_cnt++; $display("FAIL u_hex_q: got %h want 00012345", q); end
    vec_cnt++; if (r !== 32'h0000_0678) begin err_cnt++; $display("FAIL u_hex_r: got %h want 00000678", r); end
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, lat, q, r, dz);
    vec_cnt++; if (q !== 32'h7FFF_FFFC) begin err_cnt++; $display("FAIL u_neg7_q: got %h want 7ffffffc", q); end
    vec_cnt++; if (r !== 32'h1) begin err_cnt++; $display("FAIL u_neg7_r: got %h want 1", r); end
  endtask

  task automatic test_signed();
    int lat; logic [31:0] q, r; logic dz;
    logic [31:0] eq0, er0, eq1, er1, eq2, er2;
`ifdef DIV_SIGNED_EN
    eq0 = 32'hFFFF_FFFD; er0 = 32'hFFFF_FFFF;
    eq1 = 32'hFFFF_FFFD; er1 = 32'h1;
    eq2 = 32'h2;         er2 = 32'hFFFF_FFFE;
`else
    eq0 = 32'h7FFF_FFFC; er0 = 32'h1;
    eq1 = 32'h0;         er1 = 32'h7;
    eq2 = 32'h0;         er2 = 32'hFFFF_FFF8;
`endif
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, q, r, dz);
    vec_cnt++; if (q !== eq0) begin err_cnt++; $display("FAIL s_m7_2_q: got %h want %h", q, eq0); end
    vec_cnt++; if (r !== er0) begin err_cnt++; $display("FAIL s_m7_2_r: got %h want %h", r, er0); end
    vec_cnt++; if (lat !== LAT_NORM) begin err_cnt++; $display("FAIL s_m7_2_lat: got %0d want %0d", lat, LAT_NORM); end
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, q, r, dz);
    vec_cnt++; if (q !== eq1) begin err_cnt++; $display("FAIL s_7_m2_q: got %h want %h", q, eq1); end
    vec_cnt++; if (r !== er1) begin err_cnt++; $display("FAIL s_7_m2_r: got %h want %h", r, er1); end
    run_op(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, lat, q, r, dz);
    vec_cnt++; if (q !== eq2) begin err_cnt++; $display("FAIL s_m8_m3_q: got %h want %h", q, eq2); end
    vec_cnt++; if (r !== er2) begin err_cnt++; $display("FAIL s_m8_m3_r: got %h want %h", r, er2); end
  endtask

  task automatic test_dbz();
    int lat; logic [31:0] q, r; logic dz;
    run_op(1'b0, 32'd5, 32'd0, lat, q, r, dz);
    vec_cnt++; if (q !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL dbz_q: got %h want ffffffff", q); end
    vec_cnt++; if (r !== 32'd5) begin err_cnt++; $display("FAIL dbz_r: got %h want 5", r); end
    vec_cnt++; if (dz !== 1'b1) begin err_cnt++; $display("FAIL dbz_flag: got %b want 1", dz); end
    vec_cnt++; if (lat !== 1) begin err_cnt++; $display("FAIL dbz_lat: got %0d want 1", lat); end
    @(negedge clk);
    vec_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL dbz_ready: got %b want 1", ready_o); end
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, lat, q, r, dz);
    vec_cnt++; if (r !== 32'hFFFF_FFFB) begin err_cnt++; $display("FAIL dbz_s_r: got %h want fffffffb", r); end
    vec_cnt++; if (dz !== 1'b1) begin err_cnt++; $display("FAIL dbz_s_flag: got %b want 1", dz); end
    run_op(1'b0, 32'd9, 32'd3, lat, q, r, dz);
    vec_cnt++; if (dz !== 1'b0) begin err_cnt++; $display("FAIL dbz_clear: got %b want 0", dz); end
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] q, r; logic dz;
    logic [31:0] eq, er; int el;
`ifdef DIV_SIGNED_EN
    eq = 32'h8000_0000; er = 32'h0; el = 1;
`else
    eq = 32'h0; er = 32'h8000_0000; el = LAT_NORM;
`endif
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, q, r, dz);
    vec_cnt++; if (q !== eq) begin err_cnt++; $display("FAIL ovf_q: got %h want %h", q, eq); end
    vec_cnt++; if (r !== er) begin err_cnt++; $display("FAIL ovf_r: got %h want %h", r, er); end
    vec_cnt++; if (dz !== 1'b0) begin err_cnt++; $display("FAIL ovf_dbz: got %b want 0", dz); end
    vec_cnt++; if (lat !== el) begin err_cnt++; $display("FAIL ovf_lat: got %0d want %0d", lat, el); end
  endtask

  task automatic test_back_to_back();
    int dones, c_b; bit got_b;
    logic [31:0] exp_q, exp_r;
    while (!ready_o) @(negedge clk);
    start = 1'b1; sgn = 1'b0; dividend = 32'd100; divisor = 32'd7;
    exp_q = 32'd14; exp_r = 32'd2;
    dones = 0; c_b = 0; got_b = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= 120 && dones < 2; c++) begin
      dividend = 32'd1000 + 32'(c) * 32'd37;
      divisor  = 32'd3 + 32'(c);
      @(negedge clk);
      if (done_o) begin
        dones++;
        vec_cnt++; if (quotient_o !== exp_q) begin err_cnt++; $display("FAIL b2b_q%0d: got %h want %h", dones, quotient_o, exp_q); end
        vec_cnt++; if (remainder_o !== exp_r) begin err_cnt++; $display("FAIL b2b_r%0d: got %h want %h", dones, remainder_o, exp_r); end
        if (dones == 1) begin
          vec_cnt++; if (c !== LAT_NORM) begin err_cnt++; $display("FAIL b2b_lat1: got %0d want %0d", c, LAT_NORM); end
        end else begin
          start = 1'b0;
          vec_cnt++; if (c - c_b !== LAT_NORM) begin err_cnt++; $display("FAIL b2b_lat2: got %0d want %0d", c - c_b, LAT_NORM); end
        end
      end else if (ready_o && dones == 1 && !got_b) begin
        got_b = 1'b1; c_b = c;
        exp_q = dividend / divisor;
        exp_r = dividend % divisor;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    vec_cnt++; if (dones !== 2) begin err_cnt++; $display("FAIL b2b_dones: got %0d want 2", dones); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones; int lat; logic [31:0] q, r; logic dz;
    while (!ready_o) @(negedge clk);
    start = 1'b1; sgn = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vec_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL mid_ready: got %b want 1", ready_o); end
    vec_cnt++; if (quotient_o !== 32'h0) begin err_cnt++; $display("FAIL mid_quot: got %h want 0", quotient_o); end
    vec_cnt++; if (remainder_o !== 32'h0) begin err_cnt++; $display("FAIL mid_rem: got %h want 0", remainder_o); end
    vec_cnt++; if (dbz_o !== 1'b0) begin err_cnt++; $display("FAIL mid_dbz: got %b want 0", dbz_o); end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    vec_cnt++; if (dones !== 0) begin err_cnt++; $display("FAIL mid_no_done: got %0d want 0", dones); end
    run_op(1'b0, 32'd1000, 32'd10, lat, q, r, dz);
    vec_cnt++; if (q !== 32'd100) begin err_cnt++; $display("FAIL mid_recover_q: got %h want %h", q, 32'd100); end
    vec_cnt++; if (r !== 32'd0) begin err_cnt++; $display("FAIL mid_recover_r: got %h want 0", r); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_dbz();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
